// File: rtl/pipe_pkg.sv
// Shared types and defaults for the elastic pipeline stage registers.
package pipe_pkg;

  localparam int DEF_LANES  = 2;
  localparam int DEF_WIDTH  = 64;
  localparam int DEF_SIDE_W = 7;
  localparam int DEF_CNT_W  = 8;

  typedef logic [DEF_LANES-1:0]  lane_vec_t;
  typedef logic [DEF_SIDE_W-1:0] side_t;

  typedef enum logic [1:0] {EMPTY, FULL, FULL_SKID} entry_state_e;

  function automatic entry_state_e occ_state(input logic out_full, input logic skid_full);
    if (skid_full) return FULL_SKID;
    if (out_full)  return FULL;
    return EMPTY;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One storage entry of the stage: lane valids, payload and sampled sideband.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SIDE_W = DEF_SIDE_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_load,
  input  logic                   i_clear,
  input  logic [LANES-1:0]       i_kill,
  input  logic                   i_track,
  input  logic [LANES-1:0]       i_valid,
  input  logic [LANES*WIDTH-1:0] i_data,
  input  logic [SIDE_W-1:0]      i_side,
  input  logic [SIDE_W-1:0]      i_side_live,
  output logic [LANES-1:0]       o_valid,
  output logic [LANES*WIDTH-1:0] o_data,
  output logic [SIDE_W-1:0]      o_side
);

  logic [LANES-1:0]       r_valid;
  logic [LANES*WIDTH-1:0] r_data;
  logic [SIDE_W-1:0]      r_side;

  // NOTE: non-blocking assignments only in clocked blocks; payload is reset as well
  // because downstream observes out_data directly and expects zero after reset/flush.
  always_ff @(posedge clk) begin
    if (!reset || i_clear) begin
      r_valid <= '0;
      r_data  <= '0;
      r_side  <= '0;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_data  <= i_data;
      r_side  <= i_side;
    end else begin
      r_valid <= r_valid & ~i_kill;
      if (i_track) r_side <= i_side_live;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_side  = r_side;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register: output entry plus optional skid entry, flush, lane kill,
// sideband tracking, first-cycle flag and saturating stall counter.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SIDE_W = DEF_SIDE_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES-1:0]       in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic                   out_ready,
  input  logic                   flush,
  input  logic [LANES-1:0]       kill_mask,
  input  logic [SIDE_W-1:0]      side_in,
  input  logic                   wait_ex,
  output logic [SIDE_W-1:0]      side_out,
  output logic                   first_cycle,
  output logic [CNT_W-1:0]       stall_cnt
);

  entry_state_e           r_state, w_state_nxt;
  logic                   w_out_full, w_skid_full, w_in_fire, w_out_fire;
  logic                   w_out_load, w_skid_load, w_out_nxt, w_skid_nxt;
  logic [LANES-1:0]       w_out_d_valid, w_skid_d_valid, w_skid_valid;
  logic [LANES*WIDTH-1:0] w_out_d_data, w_skid_data;
  logic [SIDE_W-1:0]      w_out_d_side, w_skid_side;
  logic                   r_first_cycle;
  logic [CNT_W-1:0]       r_stall_cnt;

  assign w_out_full  = |out_valid;
  assign w_skid_full = (r_state == FULL_SKID);
  assign in_ready    = (SKID != 0) ? ~w_skid_full : (~w_out_full | out_ready);
  assign w_in_fire   = in_ready & (|in_valid);
  assign w_out_fire  = w_out_full & out_ready;
  assign w_out_load  = ~w_out_full | w_out_fire;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_out_d_valid  = w_in_fire ? in_valid : '0;
    w_out_d_data   = in_data;
    w_out_d_side   = side_in;
    if (w_skid_full) begin
      w_out_d_valid = w_skid_valid;
      w_out_d_data  = w_skid_data;
      w_out_d_side  = w_skid_side;
    end
    // Skid only captures when the output entry cannot take the group; otherwise it drains.
    w_skid_load    = w_out_load | w_in_fire;
    w_skid_d_valid = (w_in_fire && !w_out_load) ? in_valid : '0;
    w_out_nxt      = ~flush & (w_out_load ? (|w_out_d_valid) : (|(out_valid & ~kill_mask)));
    w_skid_nxt     = (SKID != 0) & ~flush & (w_skid_load ? (|w_skid_d_valid) : w_skid_full);
    w_state_nxt    = occ_state(w_out_nxt, w_skid_nxt);
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  pipe_entry #(.LANES(LANES), .WIDTH(WIDTH), .SIDE_W(SIDE_W)) u_out (
    .clk(clk), .reset(reset), .i_load(w_out_load), .i_clear(flush), .i_kill(kill_mask),
    .i_track(wait_ex), .i_valid(w_out_d_valid), .i_data(w_out_d_data), .i_side(w_out_d_side),
    .i_side_live(side_in), .o_valid(out_valid), .o_data(out_data), .o_side(side_out)
  );

  if (SKID != 0) begin : g_skid
    pipe_entry #(.LANES(LANES), .WIDTH(WIDTH), .SIDE_W(SIDE_W)) u_skid (
      .clk(clk), .reset(reset), .i_load(w_skid_load), .i_clear(flush), .i_kill('0),
      .i_track(1'b0), .i_valid(w_skid_d_valid), .i_data(in_data), .i_side(side_in),
      .i_side_live(side_in), .o_valid(w_skid_valid), .o_data(w_skid_data), .o_side(w_skid_side)
    );
  end else begin : g_no_skid
    assign w_skid_valid = '0;
    assign w_skid_data  = '0;
    assign w_skid_side  = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset || flush || w_out_load) begin
      r_first_cycle <= 1'b1;
      r_stall_cnt   <= '0;
    end else begin
      r_first_cycle <= 1'b0;
      if (!out_ready && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign first_cycle = r_first_cycle;
  assign stall_cnt   = r_stall_cnt;

endmodule
